mips_bus_arbiter: RTL and testbench
===================================

// Module: mips_bus_arbiter
// PURPOSE
//  Shares one external memory port between the core's instruction-fetch requester (I) and its
//  data load/store requester (D). One transaction is outstanding at a time. D has fixed priority;
//  a starvation counter forces an I grant after MAXWAIT consecutive D grants while I waits.
//  Sits between the pipe's code/data cache-miss paths and the bus/memory controller.
// PARAMETERS
//  MAXWAIT  4   consecutive D grants tolerated while i_req pending (>=1)
// PORTS
//  clock    in   1   single clock; all state changes on posedge
//  reset    in   1   asynchronous, active-low; clears all state immediately
//  i_req    in   1   I request; held high and stable until i_ack
//  i_addr   in   32  I word address
//  i_ack    out  1   one-cycle pulse: I transaction complete, i_data valid
//  i_data   out  32  fetched word; holds until next I completion
//  d_req    in   1   D request; held high and stable until d_ack
//  d_we     in   1   D write (1) / read (0)
//  d_be     in   4   D byte enables
//  d_addr   in   32  D address
//  d_wdata  in   32  D write data
//  d_ack    out  1   one-cycle pulse: D transaction complete
//  d_rdata  out  32  read data; updated only on D read completion
//  m_req    out  1   memory request valid
//  m_we     out  1   memory write
//  m_be     out  4   memory byte enables (I always 4'b1111)
//  m_addr   out  32  memory address
//  m_wdata  out  32  memory write data (0 for I and D reads)
//  m_rdy    in   1   memory completes current request this cycle; m_rdata valid
//  m_rdata  in   32  memory read data
//  owner    out  2   00 none, 01 I, 10 D (current grant)
//  stall    out  1   (i_req & ~i_ack) | (d_req & ~d_ack), combinational
// BEHAVIOUR
//  - Reset (low): state IDLE, wcnt 0, m_req/m_we 0, m_be/m_addr/m_wdata 0, acks 0, data regs 0,
//    owner 00. In-flight memory transaction is abandoned; slave must tolerate m_req dropping.
//  - All m_* outputs and owner are registered; all m_* fields are 0 whenever m_req is 0
//    (OR-bus convention).
//  - FSM: IDLE -> GNT_I | GNT_D -> IDLE.
//    IDLE: eligible = req high and own ack not high this cycle (blocks re-grant in ack cycle).
//      pick D if D eligible and (I not eligible or wcnt < MAXWAIT); else I if eligible; else stay.
//      on grant: latch request fields into m_* and raise m_req at the same edge.
//    GNT_x: hold m_* stable until m_rdy; on m_rdy edge: m_req<=0, fields<=0, ack_x<=1,
//      read data captured (I always; D only if !m_we), -> IDLE.
//  - Latency: req seen in IDLE cycle n -> m_req high n+1 -> with m_rdy in n+1, ack high n+2.
//    Minimum 2 cycles req->ack; 1-cycle IDLE bubble between back-to-back transactions.
//  - m_rdy while IDLE ignored. Request fields changing while granted are ignored (latched copy).
//  - wcnt: +1 (saturating at MAXWAIT) on each D grant made while i_req high; cleared on I grant
//    or whenever i_req is low in IDLE.
//  - Simultaneous i_req/d_req with wcnt<MAXWAIT: D wins; at wcnt==MAXWAIT: I wins.
//  - acks never both high in one cycle; ack high for exactly one cycle.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE, GNT_I, GNT_D), owner codes, I byte-enable
//    constant 4'b1111.
//  - One natural sub-module: mips_arb_pick (combinational grant select from eligible flags and
//    wcnt); FSM, counter and output registers stay in the top.
// TESTING
//  1 Reset: reset low mid GNT_D -> m_req, acks, owner 0 within same cycle; after release IDLE.
//  2 Single I read, m_rdy same cycle as m_req, m_rdata=0x0C000008 -> i_ack at n+2,
//    i_data=0x0C000008, m_be=1111.
//  3 Simultaneous i_req,d_req (D write, be=0011, wdata=0xBEEF) -> D granted first, m_wdata=0xBEEF,
//    d_rdata unchanged; I granted next transaction.
//  4 D held continuously, I pending, MAXWAIT=4 -> exactly 4 D grants then 1 I grant; wcnt 0.
//  5 Wait states: m_rdy low 3 cycles -> m_* stable, stall high, no ack until m_rdy.
//  6 Requester keeps req high in ack cycle -> no duplicate grant; m_rdy in IDLE ignored.

Source files
------------

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared definitions for the I/D memory-port arbiter: FSM states,
// owner codes and the fixed instruction-fetch byte enable.
package mips_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_I = 2'b01,
    ST_GNT_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // Instruction fetches are always full-word.
  localparam logic [3:0] I_BE = 4'b1111;

  // Width of a counter that must be able to hold the value maxwait.
  function automatic int cnt_width(input int maxwait);
    return (maxwait < 1) ? 1 : $clog2(maxwait + 1);
  endfunction

endpackage

// File: rtl/mips_arb_pick.sv
// Grant select: D has fixed priority unless I has already waited through
// MAXWAIT consecutive D grants.
module mips_arb_pick #(
  parameter int MAXWAIT = 4,
  parameter int WCW     = 3
) (
  input  logic           i_elig,
  input  logic           d_elig,
  input  logic [WCW-1:0] wcnt,
  output logic           pick_i,
  output logic           pick_d
);

  localparam logic [WCW-1:0] MAXW = WCW'(MAXWAIT);

  // D wins when eligible and I is either absent or not yet starved.
  always_comb begin
    pick_d = d_elig && (!i_elig || (wcnt < MAXW));
    pick_i = i_elig && !pick_d;
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one memory port between instruction fetch (I) and data
// load/store (D). One transaction outstanding; all bus outputs registered
// and zeroed whenever m_req is low.
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
#(
  parameter int MAXWAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_rdy,
  input  logic [31:0] m_rdata,
  output logic [1:0]  owner,
  output logic        stall
);

  localparam int WCW = cnt_width(MAXWAIT);
  localparam logic [WCW-1:0] MAXW = WCW'(MAXWAIT);

  arb_state_t     state_reg;
  logic [WCW-1:0] wcnt_reg;
  logic           i_elig;
  logic           d_elig;
  logic           pick_i;
  logic           pick_d;

  // A requester is not eligible in its own ack cycle, so a held request
  // cannot be granted twice.
  assign i_elig = i_req && !i_ack;
  assign d_elig = d_req && !d_ack;

  mips_arb_pick #(
    .MAXWAIT (MAXWAIT),
    .WCW     (WCW)
  ) u_pick (
    .i_elig (i_elig),
    .d_elig (d_elig),
    .wcnt   (wcnt_reg),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  // Requesters stall until their own ack pulse arrives.
  assign stall = (i_req && !i_ack) || (d_req && !d_ack);

  // FSM, starvation counter and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      wcnt_reg  <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_be      <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_data    <= '0;
      d_rdata   <= '0;
      owner     <= OWN_NONE;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_d) begin
            state_reg <= ST_GNT_D;
            m_req     <= 1'b1;
            m_we      <= d_we;
            m_be      <= d_be;
            m_addr    <= d_addr;
            m_wdata   <= d_we ? d_wdata : 32'h0;
            owner     <= OWN_D;
            if (i_req)
              wcnt_reg <= (wcnt_reg == MAXW) ? wcnt_reg : wcnt_reg + 1'b1;
            else
              wcnt_reg <= '0;
          end else if (pick_i) begin
            state_reg <= ST_GNT_I;
            m_req     <= 1'b1;
            m_we      <= 1'b0;
            m_be      <= I_BE;
            m_addr    <= i_addr;
            m_wdata   <= 32'h0;
            owner     <= OWN_I;
            wcnt_reg  <= '0;
          end else if (!i_req) begin
            wcnt_reg <= '0;
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (m_rdy) begin
            if (state_reg == ST_GNT_I) begin
              i_ack  <= 1'b1;
              i_data <= m_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!m_we)
                d_rdata <= m_rdata;
            end
            state_reg <= ST_IDLE;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_be      <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            owner     <= OWN_NONE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios followed by
// randomized protocol-correct traffic, all compared every cycle against a
// transaction-level reference model.
module tb_mips_bus_arbiter;

  localparam int MAXWAIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_data;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rdy = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  owner;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips_bus_arbiter #(.MAXWAIT(MAXWAIT)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_data  (i_data),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdy   (m_rdy),
    .m_rdata (m_rdata),
    .owner   (owner),
    .stall   (stall)
  );

  // Reference model: which requester holds the bus (if any), its latched
  // transaction, completion pulses, returned data, and how many D grants
  // in a row have been made while I was waiting.
  bit          busy;
  bit          holder_d;
  logic        e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic        e_iack;
  logic        e_dack;
  logic [31:0] e_idata;
  logic [31:0] e_drdata;
  int          d_streak;
  int          n_i_grants;
  int          n_d_grants;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; holder_d = 0;
    e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0;
    e_iack = 0; e_dack = 0; e_idata = '0; e_drdata = '0;
    d_streak = 0;
  endtask

  // Compare every DUT output against the model (called just after an edge).
  task automatic compare_all(input string tag);
    logic [1:0] eo;
    eo = !busy ? 2'b00 : (holder_d ? 2'b10 : 2'b01);
    check({tag, ".m_req"},   32'(m_req),   32'(busy));
    check({tag, ".m_we"},    32'(m_we),    busy ? 32'(e_we) : 32'd0);
    check({tag, ".m_be"},    32'(m_be),    busy ? 32'(e_be) : 32'd0);
    check({tag, ".m_addr"},  m_addr,       busy ? e_addr : 32'd0);
    check({tag, ".m_wdata"}, m_wdata,      busy ? e_wdata : 32'd0);
    check({tag, ".owner"},   32'(owner),   32'(eo));
    check({tag, ".i_ack"},   32'(i_ack),   32'(e_iack));
    check({tag, ".d_ack"},   32'(d_ack),   32'(e_dack));
    check({tag, ".i_data"},  i_data,       e_idata);
    check({tag, ".d_rdata"}, d_rdata,      e_drdata);
    check({tag, ".stall"},   32'(stall),
          32'((i_req && !e_iack) || (d_req && !e_dack)));
  endtask

  // Advance one clock: decide the model's outcome from the inputs presented
  // during this cycle, then wait for the edge and compare.
  task automatic step(input string tag);
    bit i_ok, d_ok, take_d, take_i, done_i, done_d;
    i_ok = i_req && !e_iack;
    d_ok = d_req && !e_dack;
    take_d = !busy && d_ok && (!i_ok || d_streak < MAXWAIT);
    take_i = !busy && !take_d && i_ok;
    done_i = busy && m_rdy && !holder_d;
    done_d = busy && m_rdy && holder_d;
    @(posedge clock);
    #1;
    e_iack = done_i;
    e_dack = done_d;
    if (done_i) e_idata = m_rdata;
    if (done_d && !e_we) e_drdata = m_rdata;
    if (done_i || done_d) busy = 0;
    if (take_d) begin
      busy = 1; holder_d = 1; n_d_grants++;
      e_we = d_we; e_be = d_be; e_addr = d_addr;
      e_wdata = d_we ? d_wdata : 32'd0;
      d_streak = i_req ? ((d_streak + 1 > MAXWAIT) ? MAXWAIT : d_streak + 1) : 0;
    end else if (take_i) begin
      busy = 1; holder_d = 0; n_i_grants++;
      e_we = 0; e_be = 4'b1111; e_addr = i_addr; e_wdata = 32'd0;
      d_streak = 0;
    end else if (!busy && !i_req && !(done_i || done_d)) begin
      d_streak = 0;
    end else if (!busy && !i_req && (done_i || done_d)) begin
      d_streak = 0;
    end
    compare_all(tag);
  endtask

  initial begin : main
    int cyc;
    int wait_cyc;
    logic [31:0] held_addr;

    // ---- initial reset
    model_reset();
    n_i_grants = 0; n_d_grants = 0;
    #2;
    compare_all("reset0");
    @(negedge clock);
    reset = 1'b1;
    step("idle0");

    // ---- Single I read, memory ready at once
    i_req = 1; i_addr = 32'h0000_0100; m_rdy = 1; m_rdata = 32'h0C00_0008;
    step("i_grant");
    check("i_grant.m_be_full", 32'(m_be), 32'hF);
    step("i_done");
    check("i_done.ack_n2", 32'(i_ack), 32'd1);
    check("i_done.i_data", i_data, 32'h0C00_0008);
    i_req = 0; m_rdy = 0;
    step("i_after");

    // ---- Simultaneous I and D: D write goes first, I next
    i_req = 1; i_addr = 32'h0000_0200;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h0000_1000; d_wdata = 32'h0000_BEEF;
    m_rdata = 32'h1234_5678;
    step("sim_grant");
    check("sim_grant.owner_d", 32'(owner), 32'h2);
    check("sim_grant.m_wdata", m_wdata, 32'h0000_BEEF);
    check("sim_grant.m_be", 32'(m_be), 32'h3);
    m_rdy = 1;
    step("sim_d_done");
    check("sim_d_done.d_rdata_kept", d_rdata, 32'd0);
    d_req = 0; m_rdy = 0;
    step("sim_i_grant");
    check("sim_i_grant.owner_i", 32'(owner), 32'h1);

    // ---- Wait states: three cycles without m_rdy
    held_addr = m_addr;
    for (int k = 0; k < 3; k++) begin
      step("wait");
      check("wait.addr_stable", m_addr, held_addr);
      check("wait.stall", 32'(stall), 32'd1);
      check("wait.no_ack", 32'(i_ack), 32'd0);
    end
    m_rdy = 1;
    step("wait_done");
    check("wait_done.ack", 32'(i_ack), 32'd1);

    // ---- Request held through ack cycle; m_rdy high while idle
    step("hold_ack");       // i_req still high in the ack cycle
    m_rdy = 1;
    step("hold_regrant");   // granted again only now, as a fresh request
    i_req = 0;
    step("hold_complete");
    m_rdy = 1;
    step("idle_rdy1");
    step("idle_rdy2");
    check("idle_rdy.no_req", 32'(m_req), 32'd0);

    // ---- D held continuously while I stays pending
    i_req = 1; i_addr = 32'h0000_0300;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_2000;
    m_rdy = 1; m_rdata = 32'hCAFE_0001;
    for (int k = 0; k < 12; k++) step("starve");
    i_req = 0; d_req = 0;
    step("starve_end");
    step("starve_idle");

    // ---- Reset in the middle of a D grant
    d_req = 1; d_we = 1; d_be = 4'b1100; d_addr = 32'h0000_3000; d_wdata = 32'h5555_AAAA;
    m_rdy = 0;
    step("rst_grant");
    check("rst_grant.owner_d", 32'(owner), 32'h2);
    reset = 1'b0;
    #2;
    check("rst_mid.m_req", 32'(m_req), 32'd0);
    check("rst_mid.owner", 32'(owner), 32'd0);
    check("rst_mid.d_ack", 32'(d_ack), 32'd0);
    model_reset();
    d_req = 0;
    @(negedge clock);
    reset = 1'b1;
    step("rst_idle");

    // ---- Randomized protocol-correct traffic
    wait_cyc = 0;
    for (cyc = 0; cyc < 800; cyc++) begin
      if (i_req && e_iack) i_req = ($urandom_range(0, 3) == 0);
      else if (!i_req) begin
        i_req = ($urandom_range(0, 2) == 0);
        i_addr = $urandom;
      end
      if (d_req && e_dack) d_req = ($urandom_range(0, 3) == 0);
      else if (!d_req) begin
        d_req = ($urandom_range(0, 1) == 0);
        d_we = $urandom_range(0, 1);
        d_be = 4'($urandom);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      m_rdy = ($urandom_range(0, 2) != 0);
      m_rdata = $urandom;
      step("rand");
      if (busy && !m_rdy) wait_cyc++;
    end

    // Both requesters must have been served during the run.
    check("rand.i_served", 32'(n_i_grants > 5), 32'd1);
    check("rand.d_served", 32'(n_d_grants > 5), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
